seq_divider: RTL and testbench

- Sequential unsigned restoring divider: the inverse datapath of the Booth multiplier.
- Accepts WIDTH-bit dividend and divisor on a start pulse and iterates one quotient bit per clock.
- Uses a left-shifting accumulator/quotient register pair, the mirror of the multiplier's right-shifting multi-function register.
- Sits beside the multiplier in the arithmetic unit and shares its start/done handshake style.

---
 rtl/seq_divider_pkg.sv | 17 +
 rtl/div_shift_reg.sv | 40 ++++
 rtl/seq_divider.sv | 153 +++++++++++++++
 tb/tb_seq_divider.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared arithmetic-unit definitions: controller state codes, default operand
// width and the select encodings of the multi-function shift registers.
package seq_divider_pkg;

    localparam int DEF_WIDTH = 8;

    // Controller states
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Shift-register select lines {s1, s0}, shared with the multiplier
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;

endpackage

// File: rtl/div_shift_reg.sv
// Left-shifting multi-function register: hold, parallel load or shift left
// with shift_in entering at bit 0. shift_out exposes the MSB for chaining.
module div_shift_reg
    import seq_divider_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         s1,
    input  logic         s0,
    input  logic [W-1:0] load_val,
    input  logic         shift_in,
    output logic [W-1:0] q,
    output logic         shift_out
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // Select next register contents from the mode lines (11 behaves as hold)
    always_comb begin
        data_d = data_q;
        case ({s1, s0})
            MODE_LOAD: data_d = load_val;
            MODE_SHL:  data_d = {data_q[W-2:0], shift_in};
            default:   data_d = data_q;
        endcase
    end

    // Register update with synchronous clear
    always_ff @(posedge clock) begin
        if (reset) data_q <= '0;
        else       data_q <= data_d;
    end

    assign q         = data_q;
    assign shift_out = data_q[W-1];

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// A (WIDTH+1 bits) and Q (WIDTH bits) form a left-shifting pair; Q's MSB
// feeds A's LSB. On a restore A simply takes the shifted value through its
// shift path; on success it loads the trial difference.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [1:0]       a_mode, q_mode;
    logic [WIDTH:0]   a_load;
    logic [WIDTH-1:0] q_load;
    logic [WIDTH:0]   a_val;
    logic [WIDTH-1:0] q_val;
    logic             q_msb;
    logic             a_msb;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH:0]   a_new;
    logic [WIDTH-1:0] q_new;

    // A[WIDTH] is always zero because A < M holds between iterations
    logic             top_bits_unused;
    assign top_bits_unused = ^{a_msb, a_val[WIDTH], q_val[WIDTH-1]};

    div_shift_reg #(.W(WIDTH + 1)) u_a_reg (
        .clock     (clock),
        .reset     (reset),
        .s1        (a_mode[1]),
        .s0        (a_mode[0]),
        .load_val  (a_load),
        .shift_in  (q_msb),
        .q         (a_val),
        .shift_out (a_msb)
    );

    div_shift_reg #(.W(WIDTH)) u_q_reg (
        .clock     (clock),
        .reset     (reset),
        .s1        (q_mode[1]),
        .s0        (q_mode[0]),
        .load_val  (q_load),
        .shift_in  (~borrow),
        .q         (q_val),
        .shift_out (q_msb)
    );

    // Trial subtraction on the shifted accumulator; borrow means restore
    always_comb begin
        shifted = {a_val[WIDTH-1:0], q_msb};
        trial   = shifted - {1'b0, m_q};
        borrow  = trial[WIDTH];
        a_new   = borrow ? shifted : trial;
        q_new   = {q_val[WIDTH-2:0], ~borrow};
    end

    // Controller: operand capture, iteration count and result write-back
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        a_mode  = MODE_HOLD;
        q_mode  = MODE_HOLD;
        a_load  = '0;
        q_load  = '0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    m_d    = divisor;
                    cnt_d  = '0;
                    a_mode = MODE_LOAD;
                    a_load = '0;
                    q_mode = MODE_LOAD;
                    q_load = dividend;
                    if (divisor == '0) begin
                        state_d = ST_DONE;
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                a_mode = borrow ? MODE_SHL : MODE_LOAD;
                a_load = trial;
                q_mode = MODE_SHL;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                    quo_d   = q_new;
                    rem_d   = a_new[WIDTH-1:0];
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller and result registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomised self-checking bench for seq_divider (WIDTH=8). Expected results
// come from plain integer division; expected timing from the edge count.
module tb_seq_divider;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    seq_divider #(.WIDTH(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present operands with start for one edge, then scramble the inputs
    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
    endtask

    // Wait for done (bounded); edges counts the start edge as 1.
    // poke_at >= 0 pulses start with 10/2 in that cycle of the wait.
    task automatic wait_done(input string tag, input int a, input int b, input int poke_at);
        int edges;
        int nbusy;
        int eq, er, edz, elat, ebusy;
        edges = 1;
        nbusy = 0;
        if (b == 0) begin
            eq = 255; er = a; edz = 1; elat = 1; ebusy = 0;
        end else begin
            eq = a / b; er = a % b; edz = 0; elat = 9; ebusy = 8;
        end
        while (!done && edges < 40) begin
            if (busy) nbusy++;
            if (edges == poke_at) begin
                start    = 1'b1;
                dividend = 8'd10;
                divisor  = 8'd2;
            end else begin
                start    = 1'b0;
                dividend = 8'($urandom);
                divisor  = 8'($urandom);
            end
            tick();
            edges++;
        end
        start = 1'b0;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_latency"}, edges, elat);
        chk({tag, "_busycycles"}, nbusy, ebusy);
        chk({tag, "_busy_at_done"}, busy, 0);
        chk({tag, "_quot"}, quotient, eq);
        chk({tag, "_rem"}, remainder, er);
        chk({tag, "_dbz"}, div_by_zero, edz);
        if (b != 0) begin
            chk({tag, "_invariant"}, 32'(quotient) * 32'(b) + 32'(remainder), a);
            chk({tag, "_rem_lt_div"}, (32'(remainder) < 32'(b)), 1);
        end
    endtask

    initial begin
        int dcount;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        repeat (3) tick();
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_quot", quotient, 0);
        chk("reset_rem", remainder, 0);
        chk("reset_dbz", div_by_zero, 0);
        reset = 1'b0;
        tick();

        // 100/7 with a single-cycle done pulse and held results
        issue(8'd100, 8'd7);
        wait_done("d100_7", 100, 7, -1);
        tick();
        chk("d100_7_pulse_end", done, 0);
        repeat (3) tick();
        chk("d100_7_hold_quot", quotient, 14);
        chk("d100_7_hold_rem", remainder, 2);

        // Back-to-back: second start presented during the done cycle
        issue(8'd255, 8'd1);
        wait_done("d255_1", 255, 1, -1);
        issue(8'd7, 8'd200);
        wait_done("d7_200", 7, 200, -1);
        tick();

        // Divide by zero
        issue(8'd5, 8'd0);
        wait_done("d5_0", 5, 0, -1);
        tick();
        chk("d5_0_pulse_end", done, 0);

        // start during busy is ignored
        issue(8'd200, 8'd3);
        wait_done("d200_3_poke", 200, 3, 3);
        tick();
        chk("poke_no_restart_busy", busy, 0);
        chk("poke_no_restart_done", done, 0);

        // Reset in the middle of a division
        issue(8'd250, 8'd9);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quot", quotient, 0);
        chk("abort_rem", remainder, 0);
        dcount = 0;
        for (int i = 0; i < 15; i++) begin
            if (done || busy) dcount++;
            tick();
        end
        chk("abort_no_activity", dcount, 0);
        issue(8'd250, 8'd9);
        wait_done("d250_9", 250, 9, -1);

        // Random sweep with random gaps (gap 0 = back-to-back)
        for (int n = 0; n < 1000; n++) begin
            int a, b, gap;
            a   = int'($urandom_range(0, 255));
            b   = int'($urandom_range(1, 255));
            gap = int'($urandom_range(0, 2));
            repeat (gap) tick();
            issue(8'(a), 8'(b));
            wait_done("rand", a, b, -1);
        end
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
